l2_pmem_responder: RTL and testbench

Memory-side responder for the L2 cache's line-granular pmem interface. It accepts one 256-bit line read or write from the L2 datapath/control. It converts that request into a 4-beat, 64-bit burst transaction on the physical-memory (DRAM model) port, then returns a single-cycle completion to L2. It sits between l2_cache and physical memory and is the only block that drives the burst bus.

---
 rtl/l2_pkg.sv | 18 +
 rtl/l2_beat_buffer.sv | 39 +++
 rtl/l2_pmem_responder.sv | 123 ++++++++++++
 tb/tb_l2_pmem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared constants and types for the L2 line-to-burst memory responder.
package l2_pkg;

    localparam int L2_LINE_WIDTH  = 256;
    localparam int L2_BURST_WIDTH = 64;
    localparam int L2_OFFSET_BITS = 5;
    localparam int L2_NUM_BEATS   = L2_LINE_WIDTH / L2_BURST_WIDTH;

    typedef logic [L2_LINE_WIDTH-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } resp_state_e;

endpackage

// File: rtl/l2_beat_buffer.sv
// Line-wide shift buffer: whole-line load from L2, per-beat load from memory,
// and beat select toward memory, both indexed by the responder's beat counter.
module l2_beat_buffer
    import l2_pkg::*;
#(
    parameter  int LINE_WIDTH  = L2_LINE_WIDTH,
    parameter  int BURST_WIDTH = L2_BURST_WIDTH,
    localparam int IDX_W       = $clog2(LINE_WIDTH / BURST_WIDTH)
) (
    input  logic                   clk,
    input  logic                   load_line_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    input  logic                   load_beat_i,
    input  logic [IDX_W-1:0]       beat_idx_i,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] beat_o,
    output logic [LINE_WIDTH-1:0]  merged_o
);

    logic [LINE_WIDTH-1:0] buf_q;

    // NOTE: merged_o gets a full default before the partial overwrite, so no latch is inferred.
    always_comb begin
        merged_o = buf_q;
        merged_o[int'(beat_idx_i)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
    end

    // NOTE: pure data storage, always loaded before it is observed, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_line_i) begin
            buf_q <= line_i;
        end else if (load_beat_i) begin
            buf_q <= merged_o;
        end
    end

    assign beat_o = buf_q[int'(beat_idx_i)*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: rtl/l2_pmem_responder.sv
// Converts one L2 line read/write into a 4-beat burst on the physical-memory
// port and returns a single-cycle completion pulse to L2.
module l2_pmem_responder
    import l2_pkg::*;
#(
    parameter int LINE_WIDTH  = L2_LINE_WIDTH,
    parameter int BURST_WIDTH = L2_BURST_WIDTH,
    parameter int OFFSET_BITS = L2_OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int                NUM_BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int                CNT_W     = $clog2(NUM_BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    resp_state_e             state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [31:0]             addr_q;
    logic                    read_q;
    logic                    write_q;
    logic                    resp_q;
    logic [LINE_WIDTH-1:0]   line_q;

    logic [31:0]             address_d;
    logic [BURST_WIDTH-1:0]  beat;
    logic [LINE_WIDTH-1:0]   merged;
    logic                    load_line;
    logic                    load_beat;

    // The line offset never reaches memory; bursts are always line aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^address_i[OFFSET_BITS-1:0];

    assign address_d = {address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign load_line = (state_q == IDLE) && write_i;
    assign load_beat = (state_q == RD_BURST) && resp_i;

    l2_beat_buffer #(
        .LINE_WIDTH  (LINE_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_beat_buffer (
        .clk         (clk),
        .load_line_i (load_line),
        .line_i      (line_i),
        .load_beat_i (load_beat),
        .beat_idx_i  (cnt_q),
        .burst_i     (burst_i),
        .beat_o      (beat),
        .merged_o    (merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Writeback wins over fill when both are requested.
                    if (write_i) begin
                        addr_q  <= address_d;
                        write_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WR_BURST;
                    end else if (read_i) begin
                        addr_q  <= address_d;
                        read_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            read_q  <= 1'b0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                            // Final beat merged directly so the line is ready with resp_o.
                            if (state_q == RD_BURST) begin
                                line_q <= merged;
                            end
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign burst_o   = write_q ? beat : '0;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
    assign line_o    = line_q;

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Self-checking bench: table vectors, hand-written corner sequences and random
// traffic against a line-level memory model with its own burst responder.
module tb_l2_pmem_responder;
    import l2_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    line_t       line_i, line_o;
    logic [31:0] address_i, address_o;
    logic        read_i, write_i, resp_o;
    logic [63:0] burst_i, burst_o;
    logic        read_o, write_o, resp_i;

    always #5 clk = ~clk;

    l2_pmem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory contents (written only by the memory process) and L2's view of them.
    logic [63:0] mem [bit [31:0]];
    line_t       ref_lines [bit [31:0]];
    line_t       last_rd_line;

    bit          stray_en;
    bit          rand_gaps;
    logic [15:0] gap_pat;
    int          pat_len;
    int          gap_total    = 0;
    int          strobe_total = 0;
    int          mem_beat     = 0;
    int          burst_cycle  = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Power-on memory contents: base address in the top word, beat k ends in A0+k.
    function automatic logic [63:0] dflt_beat(input bit [31:0] key);
        return {key & 32'hFFFF_FFE0, 24'hBEEF00, 8'(8'hA0 + key[4:3])};
    endfunction

    function automatic logic [63:0] mem_rd(input bit [31:0] key);
        if (mem.exists(key)) return mem[key];
        return dflt_beat(key);
    endfunction

    function automatic line_t mem_line(input bit [31:0] base);
        line_t l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = mem_rd(base + 32'(8*k));
        return l;
    endfunction

    function automatic line_t model_line(input bit [31:0] base);
        line_t l;
        if (ref_lines.exists(base)) return ref_lines[base];
        for (int k = 0; k < 4; k++) l[64*k +: 64] = dflt_beat(base + 32'(8*k));
        return l;
    endfunction

    // Memory side: strobes beats per the gap pattern, sources reads, captures writes.
    always @(negedge clk) begin
        bit fire;
        bit [31:0] key;
        #1;
        if (!rst_n || !(read_o || write_o)) begin
            mem_beat    = 0;
            burst_cycle = 0;
            resp_i      = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            burst_i     = {$urandom, $urandom};
        end else begin
            if (burst_cycle < pat_len) fire = gap_pat[burst_cycle];
            else if (rand_gaps)        fire = ($urandom_range(0, 2) != 0);
            else                       fire = 1'b1;
            burst_cycle++;
            key = address_o + 32'(8*mem_beat);
            if (fire) begin
                resp_i = 1'b1;
                strobe_total++;
                if (read_o) burst_i = mem_rd(key);
                else        mem[key] = burst_o;
                mem_beat++;
            end else begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
                gap_total++;
            end
        end
    end

    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input line_t wdata, input line_t exp_line, input string nm);
        logic [31:0] base;
        int          n, g0;
        bit          seen;
        base = {addr[31:5], 5'b0};
        @(negedge clk);
        read_i = rd; write_i = wr; address_i = addr; line_i = wdata;
        g0 = gap_total;
        @(negedge clk);
        n = 1;
        check({nm, " address_o"}, address_o, base);
        check({nm, " rd/wr_o"}, {read_o, write_o}, {rd & ~wr, wr});
        if (wr) check({nm, " first beat"}, burst_o, wdata[63:0]);
        // Inputs after acceptance must have no effect.
        address_i = $urandom;
        line_i    = {8{$urandom}};
        seen = 0;
        while (!seen && n < 100) begin
            if (resp_o) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            check({nm, " resp timeout"}, 0, 1);
        end else begin
            check({nm, " latency"}, n, 5 + (gap_total - g0));
            check({nm, " rd/wr_o dropped"}, {read_o, write_o}, 2'b00);
            check({nm, " line_o"}, line_o, exp_line);
            read_i = 0; write_i = 0;
            @(negedge clk);
            check({nm, " resp pulse"}, resp_o, 1'b0);
            if (wr) begin
                check({nm, " mem line"}, mem_line(base), wdata);
                ref_lines[base] = wdata;
            end else begin
                last_rd_line = exp_line;
            end
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        line_t       wdata;
        line_t       exp_line;
        string       nm;
    } vec_t;

    vec_t vecs[5];

    localparam line_t W1 = {64'hD3D3_0000_1111_0003, 64'hD2D2_0000_1111_0002,
                            64'hD1D1_0000_1111_0001, 64'hD0D0_0000_1111_0000};
    localparam line_t W2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                            64'h5555_AAAA_5555_AAAA, 64'hC3C3_3C3C_C3C3_3C3C};
    localparam line_t RD0 = {64'h1234_5660_BEEF_00A3, 64'h1234_5660_BEEF_00A2,
                             64'h1234_5660_BEEF_00A1, 64'h1234_5660_BEEF_00A0};

    initial begin
        line_t wd, el;
        logic [31:0] a;
        bit rd, wr;
        int s0;

        rst_n = 0; read_i = 0; write_i = 0; address_i = 0; line_i = '0;
        stray_en = 0; rand_gaps = 0; gap_pat = '0; pat_len = 0;
        last_rd_line = '0;

        vecs[0] = '{1'b1, 1'b0, 32'h1234_5678, '0, RD0, "rd_basic"};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1FFF, W1, RD0, "rd_wr_both"};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_1FE5, '0, W1, "rd_after_wr"};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, W2, W1, "wr_top"};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFE0, '0, W2, "rd_top"};

        repeat (2) @(negedge clk);
        check("rst line_o", line_o, '0);
        check("rst burst_o", burst_o, '0);
        check("rst address_o", address_o, '0);
        check("rst rd/wr/resp", {read_o, write_o, resp_o}, 3'b000);
        rst_n = 1;

        for (int i = 0; i < 5; i++)
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_line, vecs[i].nm);

        // Write with strobe gaps 1,0,0,1,1,0,1.
        gap_pat = 16'b101_1001; pat_len = 7;
        do_txn(1'b0, 1'b1, 32'h0000_2040, W2 ^ W1, last_rd_line, "wr_gaps");
        pat_len = 0;

        // Stray strobes while idle.
        stray_en = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle stray", {read_o, write_o, resp_o}, 3'b000);
        end
        stray_en = 0;

        // Reset in the middle of a read, after two beats have transferred.
        @(negedge clk);
        s0 = strobe_total;
        read_i = 1; address_i = 32'h0000_4444;
        for (int i = 0; i < 50 && (strobe_total - s0) < 2; i++) @(negedge clk);
        check("mid-rst wait", strobe_total - s0, 2);
        rst_n = 0;
        #1;
        check("mid-rst outputs", {read_o, write_o, resp_o}, 3'b000);
        check("mid-rst line_o", line_o, '0);
        check("mid-rst address_o", address_o, '0);
        last_rd_line = '0;
        @(negedge clk);
        rst_n = 1; read_i = 0;
        repeat (2) @(negedge clk);
        check("post-rst idle", {read_o, write_o, resp_o}, 3'b000);
        do_txn(1'b1, 1'b0, 32'h0000_4444, '0, model_line(32'h0000_4440), "rd_after_rst");

        // Random traffic over a few lines with random gaps and stray strobes.
        rand_gaps = 1; stray_en = 1;
        for (int i = 0; i < 30; i++) begin
            a  = 32'h0000_8000 + 32'(32 * $urandom_range(0, 3)) + 32'($urandom_range(0, 31));
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            el = wr ? last_rd_line : model_line({a[31:5], 5'b0});
            do_txn(rd, wr, a, wd, el, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
